decision_tree: RTL and testbench

DECISION_TREE -- requirements
Module: decision_tree

---
 rtl/decision_tree.sv | 166 ++++++++++++++++
 tb/tb_decision_tree.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decision_tree.sv
// Pipelined-free binary decision tree classifier.
// A heap-ordered node table {feature index, threshold} is walked one level per
// clock; the leaf reached after DEPTH levels gives a 1-based class number.
//
// state | meaning
// IDLE  | waiting for start_i; node-table writes accepted here only
// EVAL  | walking the tree, one level per edge
// DONE  | result held on y_o/y_valid_o until y_ready_i
module decision_tree #(
    parameter int  W       = 8,
    parameter int  N_FEAT  = 3,
    parameter int  DEPTH   = 2,
    localparam int N_NODES = (1 << DEPTH) - 1,
    localparam int AW      = (N_NODES > 1) ? $clog2(N_NODES) : 1,
    localparam int FW      = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FEAT*W-1:0] x_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic [W-1:0]        y_o,
    output logic                y_valid_o,
    input  logic                y_ready_i,
    input  logic                cfg_we_i,
    input  logic [AW-1:0]       cfg_addr_i,
    input  logic [FW-1:0]       cfg_feat_i,
    input  logic [W-1:0]        cfg_thr_i,
    output logic                cfg_err_o
);

    // Node indices reach 2^(DEPTH+1)-2 once a leaf is selected.
    localparam int NW = DEPTH + 1;
    localparam int LW = 3;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

    state_e              state_q, state_d;
    logic [N_FEAT*W-1:0] x_q, x_d;
    logic [NW-1:0]       node_q, node_d;
    logic [LW-1:0]       level_q, level_d;
    logic [W-1:0]        y_q, y_d;
    logic                valid_q, valid_d;
    logic                err_q;

    logic [FW-1:0]       feat_q [N_NODES];
    logic [W-1:0]        thr_q  [N_NODES];

    logic [FW-1:0]       cur_feat;
    logic [W-1:0]        cur_thr;
    logic [W-1:0]        cur_x;
    logic                go_right;
    logic [NW-1:0]       child;
    logic                cfg_ok;

    // Tree level of heap node n, used for the reset-time table contents.
    function automatic int node_level(input int n);
        int l;
        l = 0;
        for (int i = 1; i < DEPTH; i++) begin
            if (n >= (1 << i) - 1) l = i;
        end
        return l;
    endfunction

    assign busy_o    = (state_q != IDLE);
    assign y_o       = y_q;
    assign y_valid_o = valid_q;
    assign cfg_err_o = err_q;

    assign cfg_ok = cfg_we_i && (state_q == IDLE) &&
                    (int'(cfg_addr_i) < N_NODES) && (int'(cfg_feat_i) < N_FEAT);

    // Look up the current node and the feature it tests; equality goes right.
    always_comb begin
        cur_feat = '0;
        cur_thr  = '0;
        for (int n = 0; n < N_NODES; n++) begin
            if (node_q == NW'(n)) begin
                cur_feat = feat_q[n];
                cur_thr  = thr_q[n];
            end
        end
        cur_x = '0;
        for (int f = 0; f < N_FEAT; f++) begin
            if (cur_feat == FW'(f)) cur_x = x_q[f*W +: W];
        end
        go_right = (cur_x >= cur_thr);
        child    = (node_q << 1) + NW'(1) + NW'(go_right);
    end

    // Next-state and datapath updates for the classifier FSM.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        node_d  = node_q;
        level_d = level_q;
        y_d     = y_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = x_i;
                    node_d  = '0;
                    level_d = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                node_d  = child;
                level_d = level_q + LW'(1);
                if (level_q == LW'(DEPTH - 1)) begin
                    y_d     = W'(child - NW'(N_NODES) + NW'(1));
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (y_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and result registers; rejected writes raise a one-cycle error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            node_q  <= '0;
            level_q <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            node_q  <= node_d;
            level_q <= level_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= cfg_we_i && !cfg_ok;
        end
    end

    // Node table: level-based defaults on reset, written only from IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < N_NODES; n++) begin
                feat_q[n] <= FW'(node_level(n) % N_FEAT);
                thr_q[n]  <= {1'b1, {(W-1){1'b0}}};
            end
        end else if (cfg_ok) begin
            for (int n = 0; n < N_NODES; n++) begin
                if (cfg_addr_i == AW'(n)) begin
                    feat_q[n] <= cfg_feat_i;
                    thr_q[n]  <= cfg_thr_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_decision_tree.sv
// Bench for decision_tree (W=8, N_FEAT=3, DEPTH=2) plus a DEPTH=3/N_FEAT=2 build.
module tb_decision_tree;

    logic        clk;
    logic        reset;
    logic [23:0] x_i;
    logic        start_i;
    logic        busy_o;
    logic [7:0]  y_o;
    logic        y_valid_o;
    logic        y_ready_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [1:0]  cfg_feat_i;
    logic [7:0]  cfg_thr_i;
    logic        cfg_err_o;

    logic [15:0] x3_i;
    logic        start3_i, busy3_o, y3_valid_o, y3_ready_i, cfg3_err_o;
    logic [7:0]  y3_o;

    int n_chk  = 0;
    int n_fail = 0;

    decision_tree dut (
        .clk(clk), .reset(reset), .x_i(x_i), .start_i(start_i),
        .busy_o(busy_o), .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_feat_i(cfg_feat_i),
        .cfg_thr_i(cfg_thr_i), .cfg_err_o(cfg_err_o)
    );

    decision_tree #(.W(8), .N_FEAT(2), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .x_i(x3_i), .start_i(start3_i),
        .busy_o(busy3_o), .y_o(y3_o), .y_valid_o(y3_valid_o), .y_ready_i(y3_ready_i),
        .cfg_we_i(1'b0), .cfg_addr_i(3'd0), .cfg_feat_i(1'b0),
        .cfg_thr_i(8'd0), .cfg_err_o(cfg3_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mf [3];
    int mt [3];
    int m_mode, m_cnt, m_res;
    logic m_busy, m_valid, m_err;
    logic [7:0] m_y;

    function automatic int model_class(input logic [23:0] x);
        int n;
        int v;
        n = 0;
        for (int l = 0; l < 2; l++) begin
            v = int'(x[mf[n]*8 +: 8]);
            n = 2 * n + 1 + ((v >= mt[n]) ? 1 : 0);
        end
        return n - 3 + 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_cnt = 0; m_res = 0;
            m_busy = 0; m_valid = 0; m_err = 0; m_y = 0;
            mf[0] = 0; mf[1] = 1; mf[2] = 1;
            mt[0] = 128; mt[1] = 128; mt[2] = 128;
        end else begin
            m_err = 0;
            case (m_mode)
                0: begin
                    if (cfg_we_i) begin
                        if (cfg_addr_i < 3 && cfg_feat_i < 3) begin
                            mf[cfg_addr_i] = int'(cfg_feat_i);
                            mt[cfg_addr_i] = int'(cfg_thr_i);
                        end else m_err = 1;
                    end
                    if (start_i) begin
                        m_res = model_class(x_i);
                        m_cnt = 2; m_mode = 1; m_busy = 1;
                    end
                end
                1: begin
                    if (cfg_we_i) m_err = 1;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_mode = 2; m_valid = 1; m_y = 8'(m_res);
                    end
                end
                default: begin
                    if (cfg_we_i) m_err = 1;
                    if (y_ready_i) begin
                        m_mode = 0; m_busy = 0; m_valid = 0;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("busy", busy_o, m_busy);
            check("y_valid", y_valid_o, m_valid);
            check("y", y_o, m_y);
            check("cfg_err", cfg_err_o, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rb();
        case ($urandom_range(0, 5))
            0: return 8'h7F;
            1: return 8'h80;
            2: return 8'h81;
            3: return 8'h00;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic classify(input logic [23:0] x, input logic [7:0] exp, input string nm);
        int lat;
        check({nm, "_model"}, model_class(x), exp);
        x_i = x; start_i = 1; tick; start_i = 0;
        lat = 0;
        while (!y_valid_o && lat < 20) begin tick; lat++; end
        check({nm, "_latency"}, lat, 2);
        check({nm, "_y"}, y_o, exp);
        check({nm, "_busy_done"}, busy_o, 1);
        y_ready_i = 1; tick; y_ready_i = 0;
        check({nm, "_valid_clr"}, y_valid_o, 0);
        check({nm, "_idle"}, busy_o, 0);
        check({nm, "_y_held"}, y_o, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] f, input logic [7:0] t,
                      input logic exp_err, input string nm);
        cfg_we_i = 1; cfg_addr_i = a; cfg_feat_i = f; cfg_thr_i = t;
        tick; cfg_we_i = 0;
        check({nm, "_err"}, cfg_err_o, exp_err);
        tick;
        check({nm, "_err_clr"}, cfg_err_o, 0);
    endtask

    task automatic run3(input logic [15:0] x, input logic [7:0] exp, input string nm);
        int lat;
        x3_i = x; start3_i = 1; tick; start3_i = 0;
        lat = 0;
        while (!y3_valid_o && lat < 20) begin tick; lat++; end
        check({nm, "_latency"}, lat, 3);
        check({nm, "_y"}, y3_o, exp);
        y3_ready_i = 1; tick; y3_ready_i = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        reset = 0; x_i = '0; start_i = 0; y_ready_i = 0;
        cfg_we_i = 0; cfg_addr_i = '0; cfg_feat_i = '0; cfg_thr_i = '0;
        x3_i = '0; start3_i = 0; y3_ready_i = 0;
        tick; tick;
        check("rst_busy", busy_o, 0);
        check("rst_valid", y_valid_o, 0);
        check("rst_y", y_o, 0);
        check("rst_err", cfg_err_o, 0);
        reset = 1;
        tick;

        classify({8'h80, 8'h80, 8'h80}, 8'd4, "c4");
        classify({8'h00, 8'h80, 8'h08}, 8'd2, "c2");
        classify({8'h00, 8'h01, 8'h08}, 8'd1, "c1");
        classify({8'h00, 8'h01, 8'h80}, 8'd3, "c3");

        // Backpressure: result held, start ignored.
        x_i = {8'h80, 8'h80, 8'h80}; start_i = 1; tick; start_i = 0;
        lat = 0;
        while (!y_valid_o && lat < 20) begin tick; lat++; end
        check("bp_latency", lat, 2);
        for (int i = 0; i < 10; i++) begin
            start_i = 1; x_i = {rb(), rb(), rb()};
            tick;
            check("bp_valid", y_valid_o, 1);
            check("bp_y", y_o, 4);
            check("bp_busy", busy_o, 1);
        end
        start_i = 0; y_ready_i = 1; tick; y_ready_i = 0;
        check("bp_release", busy_o, 0);

        // Reprogramming.
        wr(2'd0, 2'd2, 8'h02, 1'b0, "wr_n0");
        classify({8'h01, 8'h01, 8'hFF}, 8'd1, "reprog");
        cfg_we_i = 1; cfg_addr_i = 0; cfg_feat_i = 0; cfg_thr_i = 8'hFF;
        x_i = {8'hFF, 8'h80, 8'h80}; start_i = 1;
        tick; cfg_we_i = 0; start_i = 0;
        check("simul_err", cfg_err_o, 0);
        lat = 0;
        while (!y_valid_o && lat < 20) begin tick; lat++; end
        check("simul_y", y_o, 2);
        y_ready_i = 1; tick; y_ready_i = 0;

        // Rejected writes.
        wr(2'd3, 2'd0, 8'h00, 1'b1, "bad_addr");
        wr(2'd1, 2'd3, 8'h00, 1'b1, "bad_feat");
        x_i = {8'h01, 8'h01, 8'hFF}; start_i = 1; tick; start_i = 0;
        cfg_we_i = 1; cfg_addr_i = 0; cfg_feat_i = 1; cfg_thr_i = 8'h00;
        tick; cfg_we_i = 0;
        check("eval_wr_err", cfg_err_o, 1);
        lat = 0;
        while (!y_valid_o && lat < 20) begin tick; lat++; end
        check("eval_wr_y", y_o, 3);
        y_ready_i = 1; tick; y_ready_i = 0;
        check("eval_wr_err_clr", cfg_err_o, 0);
        classify({8'h01, 8'h01, 8'hFF}, 8'd3, "after_rej");

        // Reset in the middle of a traversal.
        x_i = {8'h80, 8'h80, 8'h80}; start_i = 1; tick; start_i = 0;
        check("mid_busy", busy_o, 1);
        reset = 0; #1;
        check("mr_busy", busy_o, 0);
        check("mr_valid", y_valid_o, 0);
        check("mr_y", y_o, 0);
        check("mr_err", cfg_err_o, 0);
        tick; tick;
        check("mr_no_valid", y_valid_o, 0);
        reset = 1;
        tick;
        classify({8'h80, 8'h80, 8'h80}, 8'd4, "pr4");
        classify({8'h00, 8'h80, 8'h08}, 8'd2, "pr2");

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            start_i    = ($urandom_range(0, 3) == 0);
            x_i        = {rb(), rb(), rb()};
            y_ready_i  = 1'($urandom_range(0, 1));
            cfg_we_i   = ($urandom_range(0, 7) == 0);
            cfg_addr_i = 2'($urandom_range(0, 3));
            cfg_feat_i = 2'($urandom_range(0, 3));
            cfg_thr_i  = rb();
            if (i % 500 == 250) begin
                reset = 0; #2; reset = 1;
            end
            tick;
        end
        start_i = 0; cfg_we_i = 0; y_ready_i = 1;
        tick; tick; tick; tick;
        y_ready_i = 0;

        // DEPTH=3, N_FEAT=2 build with default table.
        run3(16'h0000, 8'd1, "d3_zero");
        run3(16'hFFFF, 8'd8, "d3_ones");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
